// File: rtl/usb_dev_protocol.sv
// usb_dev_protocol
// Device-side USB protocol responder. It decodes host tokens addressed to
// DEV_ADDR. For OUT tokens it captures the following data packet and answers
// ACK or NAK. For IN tokens it sends the queued application payload and then
// consumes the host handshake.

module usb_dev_protocol #(
    parameter logic [6:0] DEV_ADDR = 7'h05,
    parameter logic [7:0] TO_MAX   = 8'd255
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [98:0] pktIn,
    input  logic        pktInAvail,
    input  logic        validIn,
    input  logic        readyEC,
    output logic [98:0] pktOut,
    output logic        pktOutAvail,
    output logic [63:0] rxData,
    output logic        rxValid,
    input  logic        rxAck,
    input  logic [63:0] txData,
    input  logic        txValid,
    output logic        txDone,
    input  logic        nrzi_idle,
    output logic        re
);

    // Packet field constants
    localparam logic [7:0]  SYNC      = 8'h01;
    localparam logic [3:0]  PID_OUT   = 4'b1000;
    localparam logic [3:0]  PID_IN    = 4'b1001;
    localparam logic [7:0]  PID_DATA  = 8'hC3;
    localparam logic [15:0] HS_ACK    = 16'h014B;
    localparam logic [15:0] HS_NAK    = 16'h015A;

    localparam logic [98:0] ACK_PKT   = {HS_ACK, 83'd0};
    localparam logic [98:0] NAK_PKT   = {HS_NAK, 83'd0};

    typedef enum logic [2:0] {
        IDLE,
        DATA_WAIT,
        SEND_ACK,
        SEND_NAK,
        SEND_DATA,
        HS_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  to_cnt;
    logic        timeout;
    logic        wait_state;

    logic        tok_hit;
    logic        tok_out;
    logic        tok_in;
    logic        data_pid;
    logic        hs_is_ack;

    logic        load_pkt;
    logic [98:0] pkt_nxt;
    logic        capture;
    logic        hs_ack_seen;
    logic        emit;

    // Trailing zero field of a data packet carries no information
    logic        unused_pkt_tail;
    assign unused_pkt_tail = ^pktIn[18:0];

    // Field decode of the incoming packet
    assign tok_hit   = pktInAvail && validIn && (pktIn[98:91] == SYNC)
                       && (pktIn[86:80] == DEV_ADDR);
    assign tok_out   = (pktIn[90:87] == PID_OUT);
    assign tok_in    = (pktIn[90:87] == PID_IN);
    assign data_pid  = (pktIn[90:83] == PID_DATA);
    assign hs_is_ack = (pktIn[98:83] == HS_ACK);

    assign wait_state = (state == DATA_WAIT) || (state == HS_WAIT);
    assign timeout    = (to_cnt == TO_MAX);

    // Next-state, outgoing packet selection and one-cycle strobes
    always_comb begin
        state_nxt   = state;
        load_pkt    = 1'b0;
        pkt_nxt     = '0;
        capture     = 1'b0;
        hs_ack_seen = 1'b0;
        emit        = 1'b0;

        unique case (state)
            IDLE: begin
                if (tok_hit) begin
                    if (tok_out) begin
                        state_nxt = DATA_WAIT;
                    end else if (tok_in) begin
                        load_pkt = 1'b1;
                        if (txValid) begin
                            state_nxt = SEND_DATA;
                            pkt_nxt   = {SYNC, PID_DATA, txData, 19'd0};
                        end else begin
                            state_nxt = SEND_NAK;
                            pkt_nxt   = NAK_PKT;
                        end
                    end
                end
            end

            // A packet decision outranks a timeout that lands in the same cycle
            DATA_WAIT: begin
                if (pktInAvail && !validIn) begin
                    state_nxt = SEND_NAK;
                    load_pkt  = 1'b1;
                    pkt_nxt   = NAK_PKT;
                end else if (pktInAvail && validIn && data_pid) begin
                    load_pkt = 1'b1;
                    if (!rxValid) begin
                        capture   = 1'b1;
                        state_nxt = SEND_ACK;
                        pkt_nxt   = ACK_PKT;
                    end else begin
                        state_nxt = SEND_NAK;
                        pkt_nxt   = NAK_PKT;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end

            SEND_ACK, SEND_NAK: begin
                if (readyEC) begin
                    emit      = 1'b1;
                    state_nxt = IDLE;
                end
            end

            SEND_DATA: begin
                if (readyEC) begin
                    emit      = 1'b1;
                    state_nxt = HS_WAIT;
                end
            end

            // Any packet ends the handshake wait; only a valid ACK completes it
            HS_WAIT: begin
                if (pktInAvail) begin
                    hs_ack_seen = validIn && hs_is_ack;
                    state_nxt   = IDLE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The encoder strobe is asserted in the same cycle it accepts the packet
    assign pktOutAvail = emit;

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait-state counter: zero on entry, counts while the wait state is held
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            to_cnt <= '0;
        end else if (wait_state && (state_nxt == state)) begin
            to_cnt <= to_cnt + 8'd1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Outgoing packet, loaded on the transition into a SEND state
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pktOut <= '0;
        end else if (load_pkt) begin
            pktOut <= pkt_nxt;
        end
    end

    // Receive buffer; a capture only happens while the buffer is empty
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rxData  <= '0;
            rxValid <= 1'b0;
        end else if (capture) begin
            rxData  <= pktIn[82:19];
            rxValid <= 1'b1;
        end else if (rxAck) begin
            rxValid <= 1'b0;
        end
    end

    // Transmit completion pulse and line read enable
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            txDone <= 1'b0;
            re     <= 1'b0;
        end else begin
            txDone <= hs_ack_seen;
            re     <= ((state == IDLE) || wait_state) && nrzi_idle;
        end
    end

endmodule
